// File: rtl/riscv_div_pkg.sv
// riscv_div_pkg: shared width, opcode and FSM state definitions for the iterative divider
package riscv_div_pkg;
  localparam int DIV_XLEN = 32;
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } div_state_e;
endpackage

// File: rtl/riscv_div_step.sv
// riscv_div_step: one restoring-division iteration (shift, trial subtract, select)
module riscv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);
  logic [XLEN+1:0] sh, trial;
  always_comb begin
    sh    = {rem_i, quo_i[XLEN-1]};
    trial = sh - {2'b00, dvs_i};
    rem_o = trial[XLEN+1] ? sh[XLEN:0] : trial[XLEN:0];
    quo_o = {quo_i[XLEN-2:0], ~trial[XLEN+1]};
  end
endmodule

// File: rtl/riscv_div.sv
// riscv_div: iterative RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle,
// valid/ready request and response channels, flush aborts any work.
module riscv_div
  import riscv_div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            div_valid_i,
  output logic            div_ready_o,
  input  logic [1:0]      div_op_i,
  input  logic [XLEN-1:0] div_a_i,
  input  logic [XLEN-1:0] div_b_i,
  input  logic            flush_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_data_o
);
  localparam int CW = $clog2(XLEN);
  div_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN:0]   rem_q, rem_d, rem_n, r_ext;
  logic [XLEN-1:0] quo_q, quo_d, quo_n, dvs_q, dvs_d, res_q, res_d;
  logic [XLEN-1:0] abs_a, abs_b, q_fix;
  logic            neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept, sgn;

  riscv_div_step #(.XLEN(XLEN)) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(dvs_q),
    .rem_o(rem_n),
    .quo_o(quo_n)
  );

  assign div_ready_o = state_q == S_IDLE;
  assign res_valid_o = state_q == S_DONE;
  assign res_data_o  = res_q;

  always_comb begin
    accept  = div_valid_i & div_ready_o & ~flush_i;
    sgn     = ~div_op_i[0];
    abs_a   = (sgn & div_a_i[XLEN-1]) ? -div_a_i : div_a_i;
    abs_b   = (sgn & div_b_i[XLEN-1]) ? -div_b_i : div_b_i;
    q_fix   = neg_q_q ? -quo_n : quo_n;
    r_ext   = neg_r_q ? -rem_n : rem_n;
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          op_d    = div_op_i;
          quo_d   = abs_a;
          dvs_d   = abs_b;
          rem_d   = '0;
          neg_q_d = sgn & (div_a_i[XLEN-1] ^ div_b_i[XLEN-1]);
          neg_r_d = sgn & div_a_i[XLEN-1];
          cnt_d   = CW'(XLEN - 1);
          state_d = (div_b_i == '0) ? S_DONE : S_CALC;
          // Divide by zero answers immediately with the raw dividend or all ones
          res_d   = (div_b_i != '0) ? res_q : (div_op_i[1] ? div_a_i : '1);
        end
        S_CALC: begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = S_DONE;
            res_d   = op_q[1] ? XLEN'(r_ext) : q_fix;
          end
        end
        S_DONE: if (res_ready_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_riscv_div.sv
// tb_riscv_div: directed checks of riscv_div results, latency, backpressure, flush and reset
module tb_riscv_div;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        div_valid_i = 1'b0;
  logic        div_ready_o;
  logic [1:0]  div_op_i = 2'b00;
  logic [31:0] div_a_i = '0;
  logic [31:0] div_b_i = '0;
  logic        flush_i = 1'b0;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic [31:0] res_data_o;
  int total = 0;
  int bad = 0;
  int lat;
  logic [31:0] held;

  riscv_div dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .div_valid_i(div_valid_i),
    .div_ready_o(div_ready_o),
    .div_op_i(div_op_i),
    .div_a_i(div_a_i),
    .div_b_i(div_b_i),
    .flush_i(flush_i),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .res_data_o(res_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    div_op_i = op;
    div_a_i = a;
    div_b_i = b;
    div_valid_i = 1'b1;
    lat = 0;
    @(posedge clk_i);
    #1;
    div_valid_i = 1'b0;
    div_a_i = $urandom;
    div_b_i = $urandom;
    lat = 1;
  endtask

  task automatic wait_res();
    while (!res_valid_o && lat < 45) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    start(op, a, b);
    wait_res();
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, res_data_o, exp);
    @(negedge clk_i);
    res_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    res_ready_i = 1'b0;
    chk({tag, "_vld_drop"}, {31'd0, res_valid_o}, 32'd0);
    chk({tag, "_rdy_back"}, {31'd0, div_ready_o}, 32'd1);
  endtask

  initial begin
    #1;
    chk("rst_ready", {31'd0, div_ready_o}, 32'd1);
    chk("rst_valid", {31'd0, res_valid_o}, 32'd0);
    chk("rst_data", res_data_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    run("div_100_7", 2'b00, 32'd100, 32'd7, 32'd14, 33);
    run("rem_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 33);
    run("div_m7_2", 2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run("rem_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run("divu_big_2", 2'b01, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 33);
    run("remu_big_2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'd1, 33);
    run("rem_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
    run("div_7_m2", 2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1);
    run("div_m5_0", 2'b00, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 1);
    run("rem_m5_0", 2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1);
    run("div_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    run("rem_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33);
    // backpressure
    start(2'b00, 32'd100, 32'd7);
    wait_res();
    chk("bp_lat", 32'(lat), 32'd33);
    held = res_data_o;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      #1;
      chk("bp_valid", {31'd0, res_valid_o}, 32'd1);
      chk("bp_data", res_data_o, 32'd14);
      chk("bp_ready", {31'd0, div_ready_o}, 32'd0);
    end
    chk("bp_held", res_data_o, held);
    @(negedge clk_i);
    res_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    res_ready_i = 1'b0;
    chk("bp_release_ready", {31'd0, div_ready_o}, 32'd1);
    chk("bp_release_valid", {31'd0, res_valid_o}, 32'd0);
    // request alongside flush is dropped
    @(negedge clk_i);
    div_valid_i = 1'b1;
    div_op_i = 2'b01;
    div_a_i = 32'd50;
    div_b_i = 32'd5;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    div_valid_i = 1'b0;
    flush_i = 1'b0;
    chk("flush_req_ready", {31'd0, div_ready_o}, 32'd1);
    // flush at iteration 10
    start(2'b01, 32'd1000, 32'd3);
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    chk("flush_ready", {31'd0, div_ready_o}, 32'd1);
    chk("flush_valid", {31'd0, res_valid_o}, 32'd0);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i);
      #1;
      if (res_valid_o) lat++;
    end
    chk("flush_no_result", 32'(lat), 32'd0);
    run("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33);
    // async reset between edges mid-CALC
    start(2'b00, 32'd100, 32'd7);
    repeat (5) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_ready", {31'd0, div_ready_o}, 32'd1);
    chk("arst_valid", {31'd0, res_valid_o}, 32'd0);
    chk("arst_data", res_data_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i);
      #1;
      if (res_valid_o) lat++;
    end
    chk("arst_no_result", 32'(lat), 32'd0);
    run("after_rst", 2'b10, 32'd100, 32'd7, 32'd2, 33);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
